// File: rtl/scalar_bank_read_arbiter_pkg.sv
// ============================================================================
// Module   : scalar_rf_pkg
// Brief    : Shared constants and helpers for the scalar register-file banks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scalar_rf_pkg;

    localparam int NUM_REQ     = 4;
    localparam int NUM_BANK    = 4;
    localparam int BANK_W      = 2;
    localparam int ADDR_W      = 8;
    localparam int XLEN        = 32;
    localparam int REQ_IDX_W   = $clog2(NUM_REQ);
    localparam int RSP_LATENCY = 1;

    // Pull requester r's bank select out of the flattened bank vector.
    function automatic logic [BANK_W-1:0] bank_sel(
        input logic [NUM_REQ*BANK_W-1:0] banks,
        input int                        r
    );
        return banks[r*BANK_W +: BANK_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/scalar_bank_rr_arb.sv
// ============================================================================
// Module   : scalar_bank_rr_arb
// Brief    : NUM_REQ-wide round-robin arbiter with its own priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scalar_bank_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_gnt_valid,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_valid;
    logic [IDX_W-1:0]   w_gnt_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(
        input logic [IDX_W-1:0] base,
        input int               off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[IDX_W-1:0];
    endfunction

    // First requesting slot at or after the pointer wins.
    always_comb begin
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_valid && i_req[wrap_idx(r_ptr, k)]) begin
                w_gnt_valid                 = 1'b1;
                w_gnt_idx                   = wrap_idx(r_ptr, k);
                w_gnt[wrap_idx(r_ptr, k)]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_gnt_valid) begin
            r_ptr <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign o_gnt       = w_gnt;
    assign o_gnt_valid = w_gnt_valid;
    assign o_gnt_idx   = w_gnt_idx;

endmodule

`default_nettype wire

// File: rtl/scalar_bank_read_arbiter.sv
// ============================================================================
// Module   : scalar_bank_read_arbiter
// Brief    : Per-bank round-robin read arbitration between operand collectors
//            and the scalar register-file banks, with write-hazard deferral.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scalar_bank_read_arbiter
    import scalar_rf_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*BANK_W-1:0] req_bank_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_idx_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     wr_en_i,
    input  logic [BANK_W-1:0]        wr_bank_i,
    input  logic [ADDR_W-1:0]        wr_idx_i,
    input  logic                     flush_i,
    output logic [NUM_BANK-1:0]      bank_rsren_o,
    output logic [NUM_BANK*ADDR_W-1:0] bank_rsidx_o,
    input  logic [NUM_BANK*XLEN-1:0] bank_rs_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [NUM_REQ*XLEN-1:0]  rsp_data_o
);

    logic [NUM_REQ-1:0]   w_gnt [NUM_BANK];
    logic [NUM_BANK-1:0]  w_gnt_valid;
    logic [REQ_IDX_W-1:0] w_gnt_idx [NUM_BANK];
    logic [NUM_REQ-1:0]   w_hazard;
    logic [NUM_REQ-1:0]   w_ready;

    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [BANK_W-1:0]    r_gnt_bank [NUM_REQ];

    // A read hitting the address being written this cycle waits a cycle.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_hazard
        assign w_hazard[r] = wr_en_i
                          && (wr_bank_i == bank_sel(req_bank_i, r))
                          && (wr_idx_i  == req_idx_i[r*ADDR_W +: ADDR_W]);
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [NUM_REQ-1:0] w_elig;

        for (genvar r = 0; r < NUM_REQ; r++) begin : g_elig
            assign w_elig[r] = req_valid_i[r] && !w_hazard[r]
                            && (bank_sel(req_bank_i, r) == BANK_W'(b));
        end

        scalar_bank_rr_arb #(
            .NUM_REQ (NUM_REQ),
            .IDX_W   (REQ_IDX_W)
        ) u_arb (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_req       (w_elig),
            .o_gnt       (w_gnt[b]),
            .o_gnt_valid (w_gnt_valid[b]),
            .o_gnt_idx   (w_gnt_idx[b])
        );

        assign bank_rsren_o[b] = w_gnt_valid[b];
        assign bank_rsidx_o[b*ADDR_W +: ADDR_W] =
            w_gnt_valid[b] ? req_idx_i[w_gnt_idx[b]*ADDR_W +: ADDR_W] : '0;
    end

    // Each requester targets one bank, so OR-ing per-bank grants is exact.
    always_comb begin
        w_ready = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_ready = w_ready | w_gnt[b];
        end
    end

    assign req_ready_o = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                r_gnt_bank[r] <= '0;
            end
        end else begin
            r_rsp_valid <= w_ready & {NUM_REQ{!flush_i}};
            for (int r = 0; r < NUM_REQ; r++) begin
                r_gnt_bank[r] <= bank_sel(req_bank_i, r);
            end
        end
    end

    assign rsp_valid_o = r_rsp_valid;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_rsp
        assign rsp_data_o[r*XLEN +: XLEN] =
            r_rsp_valid[r] ? bank_rs_i[r_gnt_bank[r]*XLEN +: XLEN] : '0;
    end

endmodule

`default_nettype wire

// File: doc/scalar_bank_read_arbiter.md
Name: scalar_bank_read_arbiter

Overview:
- Shares the NUM_BANK scalar register-file banks between NUM_REQ operand-collector read requesters.
- Each cycle, for every bank, grants at most one read using a per-bank round-robin scheme.
- Drives each bank's read index and read-enable, blocks reads that collide with a same-cycle write to the same address, and routes bank read data back to the granted requester one cycle later.
- Sits between the operand collector units and the scalar_regfile_bank instances.

Parameters:
- NUM_REQ, 4, number of read requesters (collector ports).
- NUM_BANK, 4, number of scalar register banks.
- BANK_W, 2, bank-select width (clog2 NUM_BANK).
- ADDR_W, 8, per-bank entry index width (matches `DEPTH_REGBANK).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  read request valid, one per requester
- req_bank_i  in  NUM_REQ*BANK_W  target bank per requester
- req_idx_i  in  NUM_REQ*ADDR_W  entry index per requester
- req_ready_o  out  NUM_REQ  request granted this cycle (combinational)
- wr_en_i  in  1  scalar writeback enable this cycle
- wr_bank_i  in  BANK_W  writeback bank
- wr_idx_i  in  ADDR_W  writeback entry index
- flush_i  in  1  discard all in-flight responses
- bank_rsren_o  out  NUM_BANK  per-bank read enable
- bank_rsidx_o  out  NUM_BANK*ADDR_W  per-bank read index
- bank_rs_i  in  NUM_BANK*XLEN  per-bank read data, valid one cycle after rsren
- rsp_valid_o  out  NUM_REQ  response valid (registered)
- rsp_data_o  out  NUM_REQ*XLEN  response data

Behaviour:
- Reset (async, rst_n=0):
  - all round-robin pointers = 0;
  - rsp_valid_o = 0;
  - registered grant map (per requester: valid + bank id) = 0.
- Eligibility: requester r is eligible for bank b when all of these hold:
  - req_valid_i[r] = 1;
  - req_bank_i[r] = b;
  - NOT (wr_en_i && wr_bank_i == b && wr_idx_i == req_idx_i[r]).
  Read-during-write to the same address is deferred, never granted.
- Per-bank grant:
  - the first eligible requester at or after ptr[b], searching upward modulo NUM_REQ;
  - at most one grant per bank, and each requester targets exactly one bank;
  - so req_ready_o is one-hot per bank and combinational from the inputs.
- Bank drive:
  - bank_rsren_o[b] = 1 iff bank b issued a grant;
  - bank_rsidx_o[b] = req_idx of the winner, or 0 when there is no grant.
- Pointer update: on a grant to requester w, ptr[b] <= (w+1) mod NUM_REQ. With no grant, ptr[b] holds.
- Requester handshake:
  - a request is consumed only when req_ready_o=1;
  - the requester holds valid/bank/idx stable until granted (not checked by this block).
- Response, latency 1:
  - at the clock edge, rsp_valid_o[r] <= req_ready_o[r] && !flush_i, and gnt_bank_q[r] <= req_bank_i[r];
  - rsp_data_o[r] = bank_rs_i[gnt_bank_q[r]] combinationally while rsp_valid_o[r] = 1, else 0.
- Flush:
  - rsp_valid_o is cleared at the next edge;
  - grants issued in the same cycle as flush still drive the banks, but their responses are suppressed;
  - pointers still advance.
- Simultaneous events:
  - a write to a different address in the same bank does not block the read;
  - a write to the same index but a different bank does not block.
- No-request case: all outputs idle and pointers unchanged.
- Reset mid-operation: pending responses are dropped and pointers return to 0.

Decomposition:
- Shared package scalar_rf_pkg holds:
  - the NUM_BANK, BANK_W, ADDR_W and XLEN constants;
  - a function for bank-select extraction;
  - a localparam for the response latency (1).
- Natural sub-module: scalar_bank_rr_arb.
  - One NUM_REQ-wide round-robin arbiter with its own pointer register.
  - Instantiated NUM_BANK times; the top level does the eligibility masks, the read-during-write hazard check and the response mux.

Test Plan:
- Single request: r0 requests bank 1, idx 0x10; bank1 data = 0xDEADBEEF.
  - Expect req_ready_o = 0001, bank_rsren_o = 0010, bank_rsidx[1] = 0x10.
  - Next cycle: rsp_valid_o = 0001, rsp_data[0] = 0xDEADBEEF.
- Conflict round-robin: r0..r3 all request bank 2 continuously from reset.
  - Grants go r0, r1, r2, r3, r0 on successive cycles.
  - Exactly one grant per cycle; responses follow 1 cycle behind each grant.
- Parallel banks: r0→bank0, r1→bank1, r2→bank2, r3→bank3.
  - All four granted in one cycle; bank_rsren_o = 1111.
  - All four responses carry the correct bank data next cycle.
- Write hazard: r1 reads bank 3 idx 0x05 while wr_en=1, wr_bank=3, wr_idx=0x05.
  - req_ready_o[1] = 0 and bank_rsren_o[3] = 0.
  - Next cycle with wr_en=0: granted.
  - Same stimulus with wr_idx = 0x06: granted immediately.
- Flush: a grant to r2 in the same cycle as flush_i=1.
  - Bank read still issues; rsp_valid_o[2] = 0 next cycle; pointer for that bank = 3.
- Async reset mid-stream: assert rst_n=0 while rsp_valid_o=1 with pointers nonzero.
  - rsp_valid_o drops immediately.
  - After release, all requesters contend for bank 0 and r0 is granted first.
